// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble).
// One conversion runs at a time under a Start/Busy/Done handshake; BCD holds the last result.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      Bin,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   BCD
);

    localparam int CW = $clog2(WIDTH + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $fatal(1, "bin2bcd_seq: WIDTH must be within 4..16");
    end
    if (pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_bad_digits
        $fatal(1, "bin2bcd_seq: DIGITS too small to hold 2**WIDTH-1");
    end

    typedef enum logic [1:0] {IDLE, ADJUST, SHIFT} state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         cnt;
    logic [WIDTH-1:0]      bin_sr;
    logic [4*DIGITS-1:0]   bcd_sr;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [4*DIGITS-1:0]   bcd_shifted;
    logic [WIDTH-1:0]      bin_shifted;
    logic                  last_shift;

    // Per-digit +3 correction; a digit of at most 9 never exceeds 12, so no carry out.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    assign bcd_shifted = {bcd_sr[4*DIGITS-2:0], bin_sr[WIDTH-1]};
    assign bin_shifted = {bin_sr[WIDTH-2:0], 1'b0};
    assign last_shift  = (state == SHIFT) && (cnt == CW'(1));
    assign Busy        = (state != IDLE);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = ADJUST;
            ADJUST:  state_next = SHIFT;
            SHIFT:   state_next = (cnt == CW'(1)) ? IDLE : ADJUST;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, alternate adjust/shift, publish on the final shift.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt    <= '0;
            bin_sr <= '0;
            bcd_sr <= '0;
            BCD    <= '0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        bin_sr <= Bin;
                        bcd_sr <= '0;
                        cnt    <= CW'(WIDTH);
                    end
                end
                ADJUST: bcd_sr <= bcd_adj;
                SHIFT: begin
                    bcd_sr <= bcd_shifted;
                    bin_sr <= bin_shifted;
                    cnt    <= cnt - CW'(1);
                    if (last_shift) begin
                        BCD  <= bcd_shifted;
                        Done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
